hs_dpath_sfr_vld_rdy: RTL and testbench
=======================================

# hs_dpath_sfr_vld_rdy

Parameterised elastic shift register with per-stage valid bits, ready/valid handshake on both sides, and bubble collapsing. It is the flow-controlled successor of the clock-enable/sync-clear shift register. A stall at the output no longer freezes the whole chain: empty stages keep filling until the pipe holds LATENCY items. It sits between datapath producers and consumers that need a fixed minimum latency but may apply backpressure.

## Interface
- DATA_TYPE, default logic: payload type carried per stage.
- RESET_VALUE, default '0: data-register value after reset or sclr.
- LATENCY, default 1: number of stages, range 1..65535, and also the capacity in items.
- OCC_W, derived localparam = $clog2(LATENCY+1): width of the occupancy count.

Ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on its rising edge.
- areset  in  1  asynchronous, active-high reset; clears all state immediately.
- sclr  in  1  synchronous clear (flush), active-high.
- s_valid  in  1  upstream item valid.
- s_ready  out  1  block can accept an item this cycle.
- s_data  in  DATA_TYPE  upstream payload.
- m_valid  out  1  output item valid.
- m_ready  in  1  downstream accepts this cycle.
- m_data  out  DATA_TYPE  output payload; equals the last stage's data register.
- occupancy  out  OCC_W  number of valid stages (0..LATENCY), registered.
- empty  out  1  occupancy == 0, registered.

## Operation
- State per stage i in 0..LATENCY-1: vld[i] (1 bit) and dat[i] (DATA_TYPE).
- Advance enables, computed combinationally from the output back to the input:
  - en[LATENCY] = m_ready.
  - en[i] = !vld[i] || en[i+1].
- s_ready = en[0] && !sclr.
- m_valid = vld[LATENCY-1] && !sclr.
- Stage update when en[i]=1:
  - vld[i] <= upstream valid, where stage 0's upstream valid is s_valid && s_ready.
  - dat[i] <= upstream data, only when upstream valid is 1. Otherwise dat[i] holds its value (no toggling on bubbles).
- When en[i]=0, the stage holds both vld and dat.
- Transfers: in_fire = s_valid && s_ready; out_fire = m_valid && m_ready.
- occupancy <= occupancy + in_fire - out_fire. It must always equal the popcount of vld.
- sclr=1 (synchronous):
  - Next state: every vld=0, every dat=RESET_VALUE, occupancy=0, empty=1.
  - No transfer is counted on either side in that cycle, because s_ready and m_valid are forced to 0.
  - sclr has priority over every other update.
- areset=1 (asynchronous, at any time including mid-transfer):
  - All vld=0, all dat=RESET_VALUE, occupancy=0, empty=1.
  - Outputs: m_valid=0, s_ready=1 unless sclr is also asserted.
  - In-flight items are discarded.
- Ordering is strict FIFO. No item is ever dropped or duplicated.
- Boundary cases:
  - Full (occupancy==LATENCY) with m_ready=0: s_ready=0.
  - Full with m_ready=1: s_ready=1. Simultaneous accept and emit leaves occupancy unchanged.
  - Empty: m_valid=0 regardless of m_ready.
  - The design must behave correctly at LATENCY=1.

## Timing
- Minimum latency: an item accepted at edge k with all downstream stages free appears with m_valid=1 after edge k+LATENCY-1. That is, it is registered at edges k..k+LATENCY-1 and is visible LATENCY cycles after acceptance.
- Throughput: 1 item/cycle when m_ready is held high.
- Backpressure:
  - s_ready depends combinationally on m_ready through the en chain. This is the only comb in-to-out path.
  - m_valid and m_data are direct register outputs, gated only by sclr.
- occupancy and empty update on the same edge as the transfers they count.

## Structure
- Sub-module hs_dpath_sfr_vld_stage:
  - Contains one vld/dat register pair.
  - Ports: clk, areset, sclr, en, up_vld, up_dat, vld, dat.
  - Instantiated LATENCY times in a generate loop.
- The top level holds the en-chain, the handshake gating and the occupancy counter.
- The shared datapath package gets function hs_occ_width(int depth), returning $clog2(depth+1) and reused by other counted buffers. No new typedefs.

## Test plan
- Reset: LATENCY=4, assert areset mid-stream with 3 items loaded. Required: m_valid=0, occupancy=0 and empty=1 immediately, with no clock edge. After release, s_ready=1.
- Streaming: LATENCY=4, m_ready=1, push 0x01..0x10 back-to-back. Required: m_data=0x01 with m_valid 4 cycles after first accept, then one item per cycle in order, and occupancy stable at 4.
- Stall and collapse: LATENCY=4, m_ready=0, push 0xA0..0xA5. Required: exactly 4 accepted (0xA0..0xA3), then s_ready=0 and occupancy=4. Raising m_ready drains 0xA0..0xA3 in order, and s_ready rises in the same cycle.
- Bubbles: LATENCY=3, s_valid pattern 1,0,1,0 with m_ready=1. Required: m_valid pattern is the same, delayed 3 cycles, and dat holds across bubbles.
- sclr: LATENCY=4 holding 2 items, pulse sclr together with s_valid=1 and m_ready=1. Required: no transfer on either side that cycle; next cycle occupancy=0, empty=1, m_data=RESET_VALUE.
- LATENCY=1: random s_valid/m_ready over 10k cycles. Required: scoreboard output matches input order, and occupancy equals the accepted-minus-emitted count.

Source files
------------

// File: rtl/hs_dpath_sfr_vld_rdy_pkg.sv
// Shared helpers for counted datapath buffers.
// hs_occ_width gives the counter width needed to hold 0..depth inclusive.
package hs_dpath_sfr_vld_rdy_pkg;

    function automatic int hs_occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hs_dpath_sfr_vld_rdy_stage.sv
// One elastic stage: a valid bit plus a payload register, advancing when en is high.
// Latency 1 cycle; payload is only loaded for valid items, so bubbles never toggle it.
module hs_dpath_sfr_vld_stage
    import hs_dpath_sfr_vld_rdy_pkg::*;
#(
    parameter type      DATA_TYPE   = logic,
    parameter DATA_TYPE RESET_VALUE = '0
) (
    input  logic     clk,
    input  logic     areset,
    input  logic     sclr,
    input  logic     en,
    input  logic     up_vld,
    input  DATA_TYPE up_dat,
    output logic     vld,
    output DATA_TYPE dat
);

    logic     r_vld;
    DATA_TYPE r_dat;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_vld <= 1'b0;
            r_dat <= RESET_VALUE;
        end else if (sclr) begin
            r_vld <= 1'b0;
            r_dat <= RESET_VALUE;
        end else if (en) begin
            r_vld <= up_vld;
            if (up_vld) begin
                r_dat <= up_dat;
            end
        end
    end

    assign vld = r_vld;
    assign dat = r_dat;

endmodule

// File: rtl/hs_dpath_sfr_vld_rdy.sv
// Elastic LATENCY-deep shift register with valid/ready on both sides and bubble collapsing.
// Minimum latency LATENCY cycles; a stalled output only blocks input once every stage is full.
module hs_dpath_sfr_vld_rdy
    import hs_dpath_sfr_vld_rdy_pkg::*;
#(
    parameter type      DATA_TYPE   = logic,
    parameter DATA_TYPE RESET_VALUE = '0,
    parameter int       LATENCY     = 1,
    localparam int      OCC_W       = hs_occ_width(LATENCY)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             sclr,
    input  logic             s_valid,
    output logic             s_ready,
    input  DATA_TYPE         s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output DATA_TYPE         m_data,
    output logic [OCC_W-1:0] occupancy,
    output logic             empty
);

    logic [LATENCY-1:0] w_vld;
    DATA_TYPE           w_dat [LATENCY];
    logic [LATENCY:0]   w_en;
    logic               w_in_fire;
    logic               w_out_fire;
    logic [OCC_W-1:0]   w_occ_nxt;
    logic [OCC_W-1:0]   r_occ;
    logic               r_empty;

    // A stage may advance if it is a bubble or everything downstream of it advances.
    always_comb begin : p_en_chain
        w_en[LATENCY] = m_ready;
        for (int i = LATENCY - 1; i >= 0; i--) begin
            w_en[i] = !w_vld[i] || w_en[i+1];
        end
    end

    assign s_ready    = w_en[0] && !sclr;
    assign w_in_fire  = s_valid && s_ready;
    assign m_valid    = w_vld[LATENCY-1] && !sclr;
    assign m_data     = w_dat[LATENCY-1];
    assign w_out_fire = m_valid && m_ready;

    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        logic     w_up_vld;
        DATA_TYPE w_up_dat;

        if (g == 0) begin : g_head
            assign w_up_vld = w_in_fire;
            assign w_up_dat = s_data;
        end else begin : g_body
            assign w_up_vld = w_vld[g-1];
            assign w_up_dat = w_dat[g-1];
        end

        hs_dpath_sfr_vld_stage #(
            .DATA_TYPE   (DATA_TYPE),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk    (clk),
            .areset (areset),
            .sclr   (sclr),
            .en     (w_en[g]),
            .up_vld (w_up_vld),
            .up_dat (w_up_dat),
            .vld    (w_vld[g]),
            .dat    (w_dat[g])
        );
    end

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_in_fire && !w_out_fire) begin
            w_occ_nxt = r_occ + 1'b1;
        end else if (!w_in_fire && w_out_fire) begin
            w_occ_nxt = r_occ - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_occ   <= '0;
            r_empty <= 1'b1;
        end else if (sclr) begin
            r_occ   <= '0;
            r_empty <= 1'b1;
        end else begin
            r_occ   <= w_occ_nxt;
            r_empty <= (w_occ_nxt == '0);
        end
    end

    assign occupancy = r_occ;
    assign empty     = r_empty;

endmodule

// File: tb/tb_hs_dpath_sfr_vld_rdy.sv
// Bench for hs_dpath_sfr_vld_rdy at LATENCY 4, 3 and 1 (instances 0, 1, 2).
// Reference model: FIFO of (data, accept edge); head is visible once both its minimum latency and the previous departure have passed.
module tb_hs_dpath_sfr_vld_rdy;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       areset;
    logic       sclr;
    logic       sv  [3];
    logic [7:0] sd  [3];
    logic       mr  [3];
    logic       sr  [3];
    logic       mv  [3];
    logic [7:0] md  [3];
    logic       emp [3];
    logic [2:0] occ_a;
    logic [1:0] occ_b;
    logic [0:0] occ_c;

    int lat [3] = '{4, 3, 1};
    int checks   = 0;
    int failures = 0;

    hs_dpath_sfr_vld_rdy #(.DATA_TYPE(logic [7:0]), .RESET_VALUE(8'hEE), .LATENCY(4)) u_dut4 (
        .clk(clk), .areset(areset), .sclr(sclr),
        .s_valid(sv[0]), .s_ready(sr[0]), .s_data(sd[0]),
        .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md[0]),
        .occupancy(occ_a), .empty(emp[0])
    );

    hs_dpath_sfr_vld_rdy #(.DATA_TYPE(logic [7:0]), .RESET_VALUE(8'hEE), .LATENCY(3)) u_dut3 (
        .clk(clk), .areset(areset), .sclr(sclr),
        .s_valid(sv[1]), .s_ready(sr[1]), .s_data(sd[1]),
        .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md[1]),
        .occupancy(occ_b), .empty(emp[1])
    );

    hs_dpath_sfr_vld_rdy #(.DATA_TYPE(logic [7:0]), .RESET_VALUE(8'hEE), .LATENCY(1)) u_dut1 (
        .clk(clk), .areset(areset), .sclr(sclr),
        .s_valid(sv[2]), .s_ready(sr[2]), .s_data(sd[2]),
        .m_valid(mv[2]), .m_ready(mr[2]), .m_data(md[2]),
        .occupancy(occ_c), .empty(emp[2])
    );

    function automatic logic [31:0] occ_of(input int d);
        case (d)
            0:       return 32'(occ_a);
            1:       return 32'(occ_b);
            default: return 32'(occ_c);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] mq_d [$];
    int         mq_t [$];
    int         n = 0;
    int         last_out;
    logic [7:0] last_dat;

    task automatic model_clear();
        mq_d.delete();
        mq_t.delete();
        last_out = -100;
        last_dat = 8'hEE;
    endtask

    // Drive one cycle on DUT d, compare against the model, then advance the model across the edge.
    task automatic step(input int d, input logic i_sv, input logic [7:0] i_sd,
                        input logic i_mr, input logic i_sclr, output logic acc);
        int         hd;
        logic       vis, e_mv, e_sr, in_f, out_f;
        logic [7:0] e_md;
        sv[d] = i_sv;
        sd[d] = i_sd;
        mr[d] = i_mr;
        sclr  = i_sclr;
        #1;
        vis  = 1'b0;
        e_md = last_dat;
        if (mq_d.size() > 0) begin
            hd = mq_t[0] + lat[d] - 1;
            if (last_out > hd) hd = last_out;
            if (n >= hd) begin
                vis  = 1'b1;
                e_md = mq_d[0];
            end
        end
        e_mv = vis && !i_sclr;
        e_sr = !i_sclr && ((mq_d.size() < lat[d]) || i_mr);
        check("m_valid",   32'(mv[d]),  32'(e_mv));
        check("m_data",    32'(md[d]),  32'(e_md));
        check("s_ready",   32'(sr[d]),  32'(e_sr));
        check("occupancy", occ_of(d),   32'(mq_d.size()));
        check("empty",     32'(emp[d]), 32'(mq_d.size() == 0));
        in_f  = i_sv && e_sr;
        out_f = e_mv && i_mr;
        acc   = in_f;
        @(posedge clk);
        n++;
        if (i_sclr) begin
            model_clear();
        end else begin
            if (out_f) begin
                last_dat = mq_d.pop_front();
                void'(mq_t.pop_front());
                last_out = n;
            end
            if (in_f) begin
                mq_d.push_back(i_sd);
                mq_t.push_back(n);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_m_valid",   32'(mv[d]),  32'd0);
            check("rst_occupancy", occ_of(d),   32'd0);
            check("rst_empty",     32'(emp[d]), 32'd1);
            check("rst_s_ready",   32'(sr[d]),  32'd1);
            check("rst_m_data",    32'(md[d]),  32'hEE);
        end
        @(posedge clk);
        @(negedge clk);
        areset = 1'b0;
        sclr   = 1'b0;
        for (int d = 0; d < 3; d++) begin
            sv[d] = 1'b0;
            sd[d] = 8'h00;
            mr[d] = 1'b0;
        end
        model_clear();
    endtask

    task automatic rand_phase(input int d, input int ncyc);
        int   p_in, p_out;
        logic a;
        p_in  = 2;
        p_out = 2;
        for (int k = 0; k < ncyc; k++) begin
            if (k % 400 == 0) begin
                p_in  = $urandom_range(1, 4);
                p_out = $urandom_range(1, 4);
            end
            step(d, $urandom_range(0, 3) < p_in, 8'($urandom), $urandom_range(0, 3) < p_out,
                 $urandom_range(0, 127) == 0, a);
        end
    endtask

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       mr;
        logic       mv;
        logic [7:0] md;
        int         occ;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic       a;
        int         n0;
        int         idx;
        logic [7:0] got [$];

        // LATENCY=3, s_valid 1,0,1,0 with junk data on bubbles
        tbl[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'hEE, 0};
        tbl[1] = '{1'b0, 8'h99, 1'b1, 1'b0, 8'hEE, 1};
        tbl[2] = '{1'b1, 8'h22, 1'b1, 1'b0, 8'hEE, 1};
        tbl[3] = '{1'b0, 8'h99, 1'b1, 1'b1, 8'h11, 2};
        tbl[4] = '{1'b0, 8'h99, 1'b1, 1'b0, 8'h11, 1};
        tbl[5] = '{1'b0, 8'h99, 1'b1, 1'b1, 8'h22, 1};
        tbl[6] = '{1'b0, 8'h99, 1'b1, 1'b0, 8'h22, 0};
        tbl[7] = '{1'b0, 8'h99, 1'b1, 1'b0, 8'h22, 0};

        sclr = 1'b0;
        for (int d = 0; d < 3; d++) begin
            sv[d] = 1'b0;
            sd[d] = 8'h00;
            mr[d] = 1'b0;
        end
        do_reset();

        for (int r = 0; r < 8; r++) begin
            sv[1] = tbl[r].sv;
            sd[1] = tbl[r].sd;
            mr[1] = tbl[r].mr;
            #1;
            check("bub_m_valid",   32'(mv[1]),  32'(tbl[r].mv));
            check("bub_m_data",    32'(md[1]),  32'(tbl[r].md));
            check("bub_occupancy", occ_of(1),   32'(tbl[r].occ));
            check("bub_empty",     32'(emp[1]), 32'(tbl[r].occ == 0));
            check("bub_s_ready",   32'(sr[1]),  32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        do_reset();

        // Streaming 0x01..0x10 at LATENCY=4
        n0 = n;
        for (int k = 0; k < 16; k++) begin
            step(0, 1'b1, 8'(k + 1), 1'b1, 1'b0, a);
            if (k == 3) begin
                check("stream_first_valid", 32'(mv[0]), 32'd1);
                check("stream_first_data",  32'(md[0]), 32'h01);
                check("stream_occ_full",    occ_of(0),   32'd4);
                check("stream_edges",       32'(n - n0), 32'd4);
            end
        end
        for (int k = 0; k < 6; k++) step(0, 1'b0, 8'h00, 1'b1, 1'b0, a);

        // Stall and collapse
        idx = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 1'b1, 8'(8'hA0 + idx), 1'b0, 1'b0, a);
            if (a) idx++;
        end
        check("stall_accepts",   32'(idx),   32'd4);
        check("stall_s_ready",   32'(sr[0]), 32'd0);
        check("stall_occupancy", occ_of(0),  32'd4);
        mr[0] = 1'b1;
        #1;
        check("stall_s_ready_rise", 32'(sr[0]), 32'd1);
        sv[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (mv[0]) got.push_back(md[0]);
            step(0, 1'b0, 8'h00, 1'b1, 1'b0, a);
        end
        check("drain_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < got.size() && i < 4; i++) check("drain_order", 32'(got[i]), 32'(8'hA0 + i));

        // sclr with 2 items loaded, s_valid and m_ready both high
        step(0, 1'b1, 8'h31, 1'b0, 1'b0, a);
        step(0, 1'b1, 8'h32, 1'b0, 1'b0, a);
        sv[0] = 1'b1;
        mr[0] = 1'b1;
        sclr  = 1'b1;
        #1;
        check("sclr_s_ready", 32'(sr[0]), 32'd0);
        check("sclr_m_valid", 32'(mv[0]), 32'd0);
        step(0, 1'b1, 8'h33, 1'b1, 1'b1, a);
        sclr  = 1'b0;
        sv[0] = 1'b0;
        mr[0] = 1'b0;
        #1;
        check("sclr_occupancy", occ_of(0),   32'd0);
        check("sclr_empty",     32'(emp[0]), 32'd1);
        check("sclr_m_data",    32'(md[0]),  32'hEE);

        // Asynchronous reset with 3 items loaded and the head visible
        step(0, 1'b1, 8'h41, 1'b0, 1'b0, a);
        step(0, 1'b1, 8'h42, 1'b0, 1'b0, a);
        step(0, 1'b1, 8'h43, 1'b0, 1'b0, a);
        step(0, 1'b0, 8'h00, 1'b0, 1'b0, a);
        step(0, 1'b0, 8'h00, 1'b0, 1'b0, a);
        check("rst_preload_m_valid", 32'(mv[0]), 32'd1);
        check("rst_preload_occ",     occ_of(0),  32'd3);
        do_reset();
        #1;
        check("rst_release_s_ready", 32'(sr[0]), 32'd1);
        @(negedge clk);

        rand_phase(2, 10000);
        do_reset();
        rand_phase(0, 3000);
        do_reset();
        rand_phase(1, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
